dmem_arbiter: RTL

Two-port arbiter that shares the single-port data memory between the pipeline MEM stage (CPU port) and the loader/debug port (DBG port). CPU has fixed priority. A starvation counter guarantees DBG forward progress, and a bounded lock mode lets DBG run back-to-back burst transfers. The block sits between the MEM stage / debug loader and the data memory. It drives the memory's addr/we/wd and routes its combinational rd back to the granted requester.

---
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// dmem_arbiter : shares the single-port data memory between CPU and DBG ports
// Revision     : 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int DATA_MEM_SIZE = 64,
    parameter int STARVE_LIMIT  = 4,
    parameter int MAX_BURST     = 8
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wd,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [31:0] cpu_rd,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wd,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rd,

    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,

    output logic        err,
    output logic [31:0] err_addr
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [3:0]  C_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0]  C_BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [29:0] C_MEM_WORDS  = 30'(DATA_MEM_SIZE);

    state_t      r_state;
    logic [3:0]  r_starve_cnt;
    logic [7:0]  r_burst_cnt;
    logic        r_cooldown;
    logic        r_err;
    logic [31:0] r_err_addr;

    logic        w_force;
    logic        w_cpu_gnt;
    logic        w_dbg_gnt;
    logic        w_any_gnt;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wd;
    logic        w_bad;
    logic        w_burst_enter;
    logic        w_burst_exit;

    // Cooldown masks the force-grant so the CPU always gets a slot after a burst.
    // Grants are held low while reset is asserted so nothing reaches memory.
    always_comb begin
        w_force   = (r_starve_cnt == C_STARVE_MAX) && !r_cooldown;
        w_cpu_gnt = 1'b0;
        w_dbg_gnt = 1'b0;
        if (rstn) begin
            if (r_state == ST_BURST) begin
                w_dbg_gnt = dbg_req;
            end else begin
                w_dbg_gnt = dbg_req && (!cpu_req || w_force);
                w_cpu_gnt = cpu_req && !w_dbg_gnt;
            end
        end
    end

    always_comb begin
        w_any_gnt  = w_cpu_gnt || w_dbg_gnt;
        w_sel_addr = '0;
        w_sel_wd   = '0;
        w_sel_we   = 1'b0;
        if (w_cpu_gnt) begin
            w_sel_addr = cpu_addr;
            w_sel_wd   = cpu_wd;
            w_sel_we   = cpu_we;
        end else if (w_dbg_gnt) begin
            w_sel_addr = dbg_addr;
            w_sel_wd   = dbg_wd;
            w_sel_we   = dbg_we;
        end
        w_bad = w_any_gnt &&
                ((w_sel_addr[1:0] != 2'b00) || (w_sel_addr[31:2] >= C_MEM_WORDS));
    end

    always_comb begin
        w_burst_enter = (r_state == ST_ARB) && w_dbg_gnt && dbg_lock && !r_cooldown;
        w_burst_exit  = (r_state == ST_BURST) &&
                        (!dbg_lock || !dbg_req ||
                         (w_dbg_gnt && (r_burst_cnt == C_BURST_LAST)));
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign dbg_gnt   = w_dbg_gnt;
    assign cpu_stall = cpu_req && !w_cpu_gnt;
    assign cpu_rd    = (w_cpu_gnt && !w_bad) ? mem_rd : '0;
    assign dbg_rd    = (w_dbg_gnt && !w_bad) ? mem_rd : '0;
    assign mem_addr  = w_sel_addr;
    assign mem_wd    = w_sel_wd;
    assign mem_we    = w_sel_we && !w_bad;
    assign err       = r_err;
    assign err_addr  = r_err_addr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_ARB;
            r_starve_cnt <= '0;
            r_burst_cnt  <= '0;
            r_cooldown   <= 1'b0;
            r_err        <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            r_err <= w_bad;
            if (w_bad) begin
                r_err_addr <= w_sel_addr;
            end

            if (dbg_req && !w_dbg_gnt) begin
                if (r_starve_cnt != C_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= '0;
            end

            r_cooldown <= w_burst_exit;

            case (r_state)
                ST_ARB: begin
                    if (w_burst_enter) begin
                        r_state     <= ST_BURST;
                        r_burst_cnt <= 8'd1;
                    end
                end
                ST_BURST: begin
                    if (w_burst_exit) begin
                        r_state     <= ST_ARB;
                        r_burst_cnt <= '0;
                    end else if (w_dbg_gnt) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state     <= ST_ARB;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn)
        !(cpu_gnt && dbg_gnt));

    a_starve_bounded: assert property (@(posedge clk) disable iff (!rstn)
        r_starve_cnt <= C_STARVE_MAX);

endmodule
`default_nettype wire
